// File: rtl/bloke2_pkg.sv
// Shared constants for the bloke2 hash datapath: state encoding and block geometry helpers.
package bloke2_pkg;

    localparam int unsigned NUM_WORDS = 16;
    localparam int unsigned BYTE_W    = 8;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StFill = 2'd1;
    localparam logic [1:0] StFull = 2'd2;
    localparam logic [1:0] StEmit = 2'd3;

    function automatic int unsigned blk_bytes(input int unsigned w);
        return NUM_WORDS * w / BYTE_W;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/bloke2_msg_packer.sv
// Packs a byte stream into zero-padded 16-word message blocks tagged with byte count and lastness.
module bloke2_msg_packer
    import bloke2_pkg::*;
#(
    parameter int unsigned  W     = 32,
    localparam int unsigned BLK_B = blk_bytes(W),
    localparam int unsigned CNT_W = cnt_width(W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   finish,
    input  logic [7:0]             din,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic [NUM_WORDS*W-1:0] blk_data,
    output logic [CNT_W-1:0]       blk_cnt,
    output logic                   blk_last,
    output logic                   blk_valid,
    input  logic                   blk_ready,
    output logic                   idle
);

    localparam int unsigned PTR_W = $clog2(BLK_B);

    logic [1:0]             state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_WORDS*W-1:0] buf_q, buf_d;
    logic                   last_q, last_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        last_d  = last_q;
        if (start) begin
            state_d = StFill;
            ptr_d   = '0;
            cnt_d   = '0;
            buf_d   = '0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                StFill: begin
                    if (din_valid) begin
                        for (int unsigned i = 0; i < BLK_B; i++) begin
                            if (ptr_q == PTR_W'(i)) buf_d[8*i +: 8] = din;
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                    if (finish) begin
                        state_d = StEmit;
                        last_d  = 1'b1;
                    end else if (din_valid && ptr_q == PTR_W'(BLK_B - 1)) begin
                        state_d = StFull;
                    end
                end
                // Hold the full block until the next event tells us whether it is the last one.
                StFull: begin
                    if (finish) begin
                        state_d = StEmit;
                        last_d  = 1'b1;
                    end else if (din_valid) begin
                        state_d = StEmit;
                        last_d  = 1'b0;
                    end
                end
                StEmit: begin
                    if (blk_ready) begin
                        if (last_q) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StFill;
                            ptr_d   = '0;
                            buf_d   = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            last_q  <= last_d;
        end
    end

    assign din_ready = (state_q == StFill);
    assign blk_valid = (state_q == StEmit);
    assign idle      = (state_q == StIdle);
    assign blk_data  = buf_q;
    assign blk_cnt   = cnt_q;
    assign blk_last  = last_q;

endmodule

// File: tb/tb_bloke2_msg_packer.sv
// Directed bench for bloke2_msg_packer in both 2s (W=32) and 2b (W=64) configurations.
module tb_bloke2_msg_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          a_start, a_finish, a_din_valid, a_blk_ready;
    logic [7:0]    a_din;
    logic          a_din_ready, a_blk_last, a_blk_valid, a_idle;
    logic [511:0]  a_blk_data;
    logic [63:0]   a_blk_cnt;

    logic          b_start, b_finish, b_din_valid, b_blk_ready;
    logic [7:0]    b_din;
    logic          b_din_ready, b_blk_last, b_blk_valid, b_idle;
    logic [1023:0] b_blk_data;
    logic [127:0]  b_blk_cnt;

    int checks = 0;
    int errors = 0;
    logic [511:0]  exp_a;
    logic [1023:0] exp_b;

    bloke2_msg_packer #(.W(32)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .finish(a_finish), .din(a_din),
        .din_valid(a_din_valid), .din_ready(a_din_ready), .blk_data(a_blk_data),
        .blk_cnt(a_blk_cnt), .blk_last(a_blk_last), .blk_valid(a_blk_valid),
        .blk_ready(a_blk_ready), .idle(a_idle)
    );

    bloke2_msg_packer #(.W(64)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .finish(b_finish), .din(b_din),
        .din_valid(b_din_valid), .din_ready(b_din_ready), .blk_data(b_blk_data),
        .blk_cnt(b_blk_cnt), .blk_last(b_blk_last), .blk_valid(b_blk_valid),
        .blk_ready(b_blk_ready), .idle(b_idle)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic a_send(input logic [7:0] b);
        a_din = b;
        a_din_valid = 1'b1;
        tick();
        a_din_valid = 1'b0;
    endtask

    task automatic a_begin;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (a_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", a_idle); end
        checks++; if (a_din_ready !== 1'b0) begin errors++; $display("FAIL reset_din_ready: got %b want 0", a_din_ready); end
        checks++; if (a_blk_valid !== 1'b0) begin errors++; $display("FAIL reset_blk_valid: got %b want 0", a_blk_valid); end
        checks++; if (a_blk_last !== 1'b0) begin errors++; $display("FAIL reset_blk_last: got %b want 0", a_blk_last); end
        checks++; if (a_blk_cnt !== 64'd0) begin errors++; $display("FAIL reset_blk_cnt: got %h want 0", a_blk_cnt); end
        checks++; if (a_blk_data !== 512'd0) begin errors++; $display("FAIL reset_blk_data: got %h want 0", a_blk_data); end
        checks++; if (b_idle !== 1'b1) begin errors++; $display("FAIL reset_b_idle: got %b want 1", b_idle); end
        tick();
        checks++; if (a_idle !== 1'b1) begin errors++; $display("FAIL reset_idle_held: got %b want 1", a_idle); end
    endtask

    task automatic test_empty;
        a_start = 1'b1;
        a_finish = 1'b1;
        tick();
        a_start = 1'b0;
        a_finish = 1'b0;
        checks++; if ({a_din_ready, a_blk_valid} !== 2'b10) begin errors++; $display("FAIL empty_start_finish: ready,valid got %b want 10", {a_din_ready, a_blk_valid}); end
        a_finish = 1'b1;
        tick();
        a_finish = 1'b0;
        checks++; if ({a_blk_valid, a_blk_last} !== 2'b11) begin errors++; $display("FAIL empty_valid_last: got %b want 11", {a_blk_valid, a_blk_last}); end
        checks++; if (a_blk_cnt !== 64'd0) begin errors++; $display("FAIL empty_cnt: got %0d want 0", a_blk_cnt); end
        checks++; if (a_blk_data !== 512'd0) begin errors++; $display("FAIL empty_data: got %h want 0", a_blk_data); end
        a_blk_ready = 1'b1;
        tick();
        a_blk_ready = 1'b0;
        checks++; if ({a_idle, a_blk_valid} !== 2'b10) begin errors++; $display("FAIL empty_done: idle,valid got %b want 10", {a_idle, a_blk_valid}); end
    endtask

    task automatic test_abc;
        a_begin();
        a_send(8'h61);
        a_send(8'h62);
        a_send(8'h63);
        a_finish = 1'b1;
        tick();
        a_finish = 1'b0;
        exp_a = '0;
        exp_a[23:0] = 24'h636261;
        checks++; if ({a_blk_valid, a_blk_last} !== 2'b11) begin errors++; $display("FAIL abc_valid_last: got %b want 11", {a_blk_valid, a_blk_last}); end
        checks++; if (a_blk_cnt !== 64'd3) begin errors++; $display("FAIL abc_cnt: got %0d want 3", a_blk_cnt); end
        checks++; if (a_blk_data !== exp_a) begin errors++; $display("FAIL abc_data: got %h want %h", a_blk_data, exp_a); end
        a_blk_ready = 1'b1;
        tick();
        a_blk_ready = 1'b0;
        checks++; if (a_idle !== 1'b1) begin errors++; $display("FAIL abc_idle: got %b want 1", a_idle); end
    endtask

    task automatic test_full_block;
        a_begin();
        for (int i = 0; i < 64; i++) a_send(8'(i));
        for (int i = 0; i < 64; i++) exp_a[8*i +: 8] = 8'(i);
        for (int k = 0; k < 4; k++) begin
            checks++; if ({a_din_ready, a_blk_valid} !== 2'b00) begin errors++; $display("FAIL full_hold_%0d: ready,valid got %b want 00", k, {a_din_ready, a_blk_valid}); end
            tick();
        end
        a_finish = 1'b1;
        tick();
        a_finish = 1'b0;
        checks++; if ({a_blk_valid, a_blk_last} !== 2'b11) begin errors++; $display("FAIL full_valid_last: got %b want 11", {a_blk_valid, a_blk_last}); end
        checks++; if (a_blk_cnt !== 64'd64) begin errors++; $display("FAIL full_cnt: got %0d want 64", a_blk_cnt); end
        checks++; if (a_blk_data !== exp_a) begin errors++; $display("FAIL full_data: got %h want %h", a_blk_data, exp_a); end
        a_blk_ready = 1'b1;
        tick();
        a_blk_ready = 1'b0;
        checks++; if ({a_idle, a_blk_valid} !== 2'b10) begin errors++; $display("FAIL full_no_trailing: idle,valid got %b want 10", {a_idle, a_blk_valid}); end
    endtask

    task automatic test_65;
        a_begin();
        for (int i = 0; i < 64; i++) a_send(8'(i));
        for (int i = 0; i < 64; i++) exp_a[8*i +: 8] = 8'(i);
        a_din = 8'h40;
        a_din_valid = 1'b1;
        tick();
        checks++; if ({a_blk_valid, a_blk_last, a_din_ready} !== 3'b100) begin errors++; $display("FAIL b65_blk0_flags: valid,last,ready got %b want 100", {a_blk_valid, a_blk_last, a_din_ready}); end
        checks++; if (a_blk_cnt !== 64'd64) begin errors++; $display("FAIL b65_blk0_cnt: got %0d want 64", a_blk_cnt); end
        checks++; if (a_blk_data !== exp_a) begin errors++; $display("FAIL b65_blk0_data: got %h want %h", a_blk_data, exp_a); end
        a_blk_ready = 1'b1;
        tick();
        a_blk_ready = 1'b0;
        checks++; if ({a_din_ready, a_blk_valid} !== 2'b10) begin errors++; $display("FAIL b65_refill: ready,valid got %b want 10", {a_din_ready, a_blk_valid}); end
        tick();
        a_din_valid = 1'b0;
        a_finish = 1'b1;
        tick();
        a_finish = 1'b0;
        exp_a = '0;
        exp_a[7:0] = 8'h40;
        checks++; if ({a_blk_valid, a_blk_last} !== 2'b11) begin errors++; $display("FAIL b65_blk1_flags: got %b want 11", {a_blk_valid, a_blk_last}); end
        checks++; if (a_blk_cnt !== 64'd65) begin errors++; $display("FAIL b65_blk1_cnt: got %0d want 65", a_blk_cnt); end
        checks++; if (a_blk_data !== exp_a) begin errors++; $display("FAIL b65_blk1_data: got %h want %h", a_blk_data, exp_a); end
        a_blk_ready = 1'b1;
        tick();
        a_blk_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        a_begin();
        a_send(8'hAA);
        a_din = 8'hBB;
        a_din_valid = 1'b1;
        a_finish = 1'b1;
        tick();
        a_finish = 1'b0;
        a_din = 8'hCC;
        exp_a = '0;
        exp_a[15:0] = 16'hBBAA;
        for (int k = 0; k < 10; k++) begin
            checks++; if ({a_blk_valid, a_blk_last, a_din_ready} !== 3'b110) begin errors++; $display("FAIL bp_flags_%0d: valid,last,ready got %b want 110", k, {a_blk_valid, a_blk_last, a_din_ready}); end
            checks++; if (a_blk_cnt !== 64'd2) begin errors++; $display("FAIL bp_cnt_%0d: got %0d want 2", k, a_blk_cnt); end
            checks++; if (a_blk_data !== exp_a) begin errors++; $display("FAIL bp_data_%0d: got %h want %h", k, a_blk_data, exp_a); end
            tick();
        end
        a_din_valid = 1'b0;
        a_blk_ready = 1'b1;
        checks++; if (a_blk_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_at_ready: got %b want 1", a_blk_valid); end
        tick();
        a_blk_ready = 1'b0;
        checks++; if ({a_idle, a_blk_valid} !== 2'b10) begin errors++; $display("FAIL bp_accepted: idle,valid got %b want 10", {a_idle, a_blk_valid}); end
    endtask

    task automatic test_restart;
        a_begin();
        for (int i = 0; i < 10; i++) a_send(8'(8'h10 + i));
        a_begin();
        checks++; if (a_blk_cnt !== 64'd0) begin errors++; $display("FAIL restart_cnt_clear: got %0d want 0", a_blk_cnt); end
        checks++; if (a_blk_data !== 512'd0) begin errors++; $display("FAIL restart_buf_clear: got %h want 0", a_blk_data); end
        a_send(8'h31);
        a_send(8'h32);
        a_send(8'h33);
        a_finish = 1'b1;
        tick();
        a_finish = 1'b0;
        exp_a = '0;
        exp_a[23:0] = 24'h333231;
        checks++; if ({a_blk_valid, a_blk_last} !== 2'b11) begin errors++; $display("FAIL restart_flags: got %b want 11", {a_blk_valid, a_blk_last}); end
        checks++; if (a_blk_cnt !== 64'd3) begin errors++; $display("FAIL restart_cnt: got %0d want 3", a_blk_cnt); end
        checks++; if (a_blk_data !== exp_a) begin errors++; $display("FAIL restart_data: got %h want %h", a_blk_data, exp_a); end
        a_blk_ready = 1'b1;
        tick();
        a_blk_ready = 1'b0;
    endtask

    task automatic test_w64;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_din_valid = 1'b1;
        for (int i = 0; i < 128; i++) begin
            b_din = 8'(i);
            tick();
        end
        for (int i = 0; i < 128; i++) exp_b[8*i +: 8] = 8'(i);
        b_din = 8'h80;
        checks++; if ({b_din_ready, b_blk_valid} !== 2'b00) begin errors++; $display("FAIL w64_full: ready,valid got %b want 00", {b_din_ready, b_blk_valid}); end
        tick();
        checks++; if ({b_blk_valid, b_blk_last} !== 2'b10) begin errors++; $display("FAIL w64_blk0_flags: got %b want 10", {b_blk_valid, b_blk_last}); end
        checks++; if (b_blk_cnt !== 128'd128) begin errors++; $display("FAIL w64_blk0_cnt: got %0d want 128", b_blk_cnt); end
        checks++; if (b_blk_data !== exp_b) begin errors++; $display("FAIL w64_blk0_data: got %h want %h", b_blk_data, exp_b); end
        b_blk_ready = 1'b1;
        tick();
        b_blk_ready = 1'b0;
        tick();
        b_din_valid = 1'b0;
        b_finish = 1'b1;
        tick();
        b_finish = 1'b0;
        exp_b = '0;
        exp_b[7:0] = 8'h80;
        checks++; if ({b_blk_valid, b_blk_last} !== 2'b11) begin errors++; $display("FAIL w64_blk1_flags: got %b want 11", {b_blk_valid, b_blk_last}); end
        checks++; if (b_blk_cnt !== 128'd129) begin errors++; $display("FAIL w64_blk1_cnt: got %0d want 129", b_blk_cnt); end
        checks++; if (b_blk_data !== exp_b) begin errors++; $display("FAIL w64_blk1_data: got %h want %h", b_blk_data, exp_b); end
        b_blk_ready = 1'b1;
        tick();
        b_blk_ready = 1'b0;
        checks++; if (b_idle !== 1'b1) begin errors++; $display("FAIL w64_idle: got %b want 1", b_idle); end
    endtask

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_finish = 1'b0; a_din = 8'h00; a_din_valid = 1'b0; a_blk_ready = 1'b0;
        b_start = 1'b0; b_finish = 1'b0; b_din = 8'h00; b_din_valid = 1'b0; b_blk_ready = 1'b0;
        exp_a = '0;
        exp_b = '0;
        test_reset();
        test_empty();
        test_abc();
        test_full_block();
        test_65();
        test_backpressure();
        test_restart();
        test_w64();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
